fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, buffers a
// single instruction for the IF/ID register and handles EX-stage redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               StallF,
   input  logic               PCSrcE,
   input  logic [31:0]        PCTargetE,
   fetch_unit_if.master       imem,
   output logic [31:0]        InstF,
   output logic [31:0]        PCF,
   output logic [31:0]        PC4F,
   output logic               ValidF
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] fetchPc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= REQ;
         fetchPc <= RESET_PC;
         InstF   <= NOP;
         PCF     <= RESET_PC;
         ValidF  <= 1'b0;
      end else if (PCSrcE) begin
         // A redirect wins over everything; an in-flight response must still be drained.
         fetchPc <= {PCTargetE[31:2], 2'b00};
         ValidF  <= 1'b0;
         InstF   <= NOP;
         case (state)
            REQ:     state <= imem.imem_gnt    ? DROP : REQ;
            WAIT:    state <= imem.imem_rvalid ? REQ  : DROP;
            HOLD:    state <= REQ;
            DROP:    state <= DROP;
            default: state <= REQ;
         endcase
      end else begin
         case (state)
            REQ: begin
               if (imem.imem_gnt) state <= WAIT;
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  InstF   <= imem.imem_rdata;
                  PCF     <= fetchPc;
                  ValidF  <= 1'b1;
                  fetchPc <= fetchPc + 32'd4;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (!StallF) begin
                  ValidF <= 1'b0;
                  InstF  <= NOP;
                  state  <= REQ;
               end
            end
            DROP: begin
               if (imem.imem_rvalid) state <= REQ;
            end
            default: state <= REQ;
         endcase
      end
   end

   assign imem.imem_req  = (state == REQ);
   assign imem.imem_addr = fetchPc;
   assign PC4F           = PCF + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: normal fetch, stall, redirects, async reset
// and PC wrap-around on a second instance reset to 32'hFFFF_FFFC.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        StallF, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstF, PCF, PC4F;
   logic        ValidF;

   logic        wStallF, wPCSrcE;
   logic [31:0] wPCTargetE;
   logic [31:0] wInstF, wPCF, wPC4F;
   logic        wValidF;

   int nVec  = 0;
   int nMiss = 0;

   fetch_unit_if bus();
   fetch_unit_if wbus();

   fetch_unit dut (
      .clk       (clk),
      .rst       (rst),
      .StallF    (StallF),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .imem      (bus.master),
      .InstF     (InstF),
      .PCF       (PCF),
      .PC4F      (PC4F),
      .ValidF    (ValidF)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk       (clk),
      .rst       (rst),
      .StallF    (wStallF),
      .PCSrcE    (wPCSrcE),
      .PCTargetE (wPCTargetE),
      .imem      (wbus.master),
      .InstF     (wInstF),
      .PCF       (wPCF),
      .PC4F      (wPC4F),
      .ValidF    (wValidF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted, got timeout required completion");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Fetch one instruction from REQ with configurable response delay and stall length.
   task automatic doFetch(input logic [31:0] addr, input int rvDelay, input int stall);
      logic [31:0] word;
      word = 32'hA000_0000 ^ addr;
      bus.imem_gnt = 1'b1;
      nVec++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, addr}) begin
         nMiss++;
         $display("FAIL fetch_req: req/addr=%b/%h required 1/%h", bus.imem_req, bus.imem_addr, addr);
      end
      cyc();
      bus.imem_gnt = 1'b0;
      for (int i = 0; i < rvDelay; i++) begin
         nVec++;
         if ({bus.imem_req, ValidF} !== 2'b00) begin
            nMiss++;
            $display("FAIL fetch_wait: req/ValidF=%b/%b required 0/0", bus.imem_req, ValidF);
         end
         cyc();
      end
      nVec++;
      if ({bus.imem_req, ValidF} !== 2'b00) begin
         nMiss++;
         $display("FAIL fetch_wait_last: req/ValidF=%b/%b required 0/0", bus.imem_req, ValidF);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word;
      cyc();
      bus.imem_rvalid = 1'b0;
      nVec++;
      if ({ValidF, InstF, PCF, PC4F, bus.imem_req} !== {1'b1, word, addr, addr + 32'd4, 1'b0}) begin
         nMiss++;
         $display("FAIL fetch_capture: V=%b I=%h PC=%h PC4=%h req=%b required 1 %h %h %h 0",
                  ValidF, InstF, PCF, PC4F, bus.imem_req, word, addr, addr + 32'd4);
      end
      for (int i = 0; i < stall; i++) begin
         StallF = 1'b1;
         cyc();
         nVec++;
         if ({ValidF, InstF, PCF, bus.imem_req} !== {1'b1, word, addr, 1'b0}) begin
            nMiss++;
            $display("FAIL stall_hold: V=%b I=%h PC=%h req=%b required 1 %h %h 0",
                     ValidF, InstF, PCF, bus.imem_req, word, addr);
         end
      end
      StallF = 1'b0;
      cyc();
      nVec++;
      if ({ValidF, InstF, PCF, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, addr, 1'b1, addr + 32'd4}) begin
         nMiss++;
         $display("FAIL fetch_consume: V=%b I=%h PC=%h req=%b addr=%h required 0 %h %h 1 %h",
                  ValidF, InstF, PCF, bus.imem_req, bus.imem_addr, NOP, addr, addr + 32'd4);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      nVec++;
      if ({ValidF, InstF, PCF, PC4F} !== {1'b0, NOP, 32'h0, 32'h4}) begin
         nMiss++;
         $display("FAIL reset_outputs: V=%b I=%h PC=%h PC4=%h required 0 %h 0 4", ValidF, InstF, PCF, PC4F, NOP);
      end
      rst = 1'b1;
      nVec++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
         nMiss++;
         $display("FAIL reset_first_req: req/addr=%b/%h required 1/00000000", bus.imem_req, bus.imem_addr);
      end
      nVec++;
      if ({wbus.imem_req, wbus.imem_addr, wPCF, wPC4F} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
         nMiss++;
         $display("FAIL reset_wrap_inst: req=%b addr=%h PC=%h PC4=%h required 1 fffffffc fffffffc 0",
                  wbus.imem_req, wbus.imem_addr, wPCF, wPC4F);
      end
   endtask

   task automatic test_zero_wait();
      doFetch(32'h0, 0, 0);
      doFetch(32'h4, 0, 0);
   endtask

   task automatic test_stall();
      doFetch(32'h8, 0, 4);
      nVec++;
      if (bus.imem_addr !== 32'hC) begin
         nMiss++;
         $display("FAIL stall_next_addr: addr=%h required 0000000c", bus.imem_addr);
      end
      doFetch(32'hC, 0, 0);
   endtask

   task automatic test_redirect_wait();
      bus.imem_gnt = 1'b1;
      nVec++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) begin
         nMiss++;
         $display("FAIL redir_wait_req: req/addr=%b/%h required 1/00000010", bus.imem_req, bus.imem_addr);
      end
      cyc();
      bus.imem_gnt = 1'b0;
      PCSrcE = 1'b1;
      PCTargetE = 32'h100;
      cyc();
      PCSrcE = 1'b0;
      for (int i = 0; i < 2; i++) begin
         nVec++;
         if ({bus.imem_req, ValidF, bus.imem_addr} !== {2'b00, 32'h100}) begin
            nMiss++;
            $display("FAIL redir_drop: req/V/addr=%b/%b/%h required 0/0/00000100", bus.imem_req, ValidF, bus.imem_addr);
         end
         if (i == 0) cyc();
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      cyc();
      bus.imem_rvalid = 1'b0;
      nVec++;
      if ({ValidF, InstF, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, 1'b1, 32'h100}) begin
         nMiss++;
         $display("FAIL redir_stale_drop: V=%b I=%h req=%b addr=%h required 0 %h 1 00000100",
                  ValidF, InstF, bus.imem_req, bus.imem_addr, NOP);
      end
      doFetch(32'h100, 1, 0);
   endtask

   task automatic test_redirect_coincident();
      bus.imem_gnt = 1'b1;
      cyc();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0001;
      PCSrcE          = 1'b1;
      PCTargetE       = 32'h202;
      cyc();
      bus.imem_rvalid = 1'b0;
      PCSrcE          = 1'b0;
      nVec++;
      if ({ValidF, InstF, PCF, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, 32'h100, 1'b1, 32'h200}) begin
         nMiss++;
         $display("FAIL redir_rvalid: V=%b I=%h PC=%h req=%b addr=%h required 0 %h 00000100 1 00000200",
                  ValidF, InstF, PCF, bus.imem_req, bus.imem_addr, NOP);
      end
      bus.imem_gnt = 1'b1;
      PCSrcE       = 1'b1;
      PCTargetE    = 32'h300;
      cyc();
      bus.imem_gnt = 1'b0;
      PCSrcE       = 1'b0;
      nVec++;
      if ({bus.imem_req, ValidF, bus.imem_addr} !== {2'b00, 32'h300}) begin
         nMiss++;
         $display("FAIL redir_gnt_drop: req/V/addr=%b/%b/%h required 0/0/00000300", bus.imem_req, ValidF, bus.imem_addr);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0002;
      cyc();
      bus.imem_rvalid = 1'b0;
      nVec++;
      if ({ValidF, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h300}) begin
         nMiss++;
         $display("FAIL redir_gnt_resume: V/req/addr=%b/%b/%h required 0/1/00000300", ValidF, bus.imem_req, bus.imem_addr);
      end
      doFetch(32'h300, 0, 0);
   endtask

   task automatic test_redirect_req();
      PCSrcE    = 1'b1;
      PCTargetE = 32'h400;
      cyc();
      PCSrcE = 1'b0;
      nVec++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h400}) begin
         nMiss++;
         $display("FAIL redir_req: req/addr=%b/%h required 1/00000400", bus.imem_req, bus.imem_addr);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0003;
      cyc();
      bus.imem_rvalid = 1'b0;
      nVec++;
      if ({ValidF, InstF, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, 1'b1, 32'h400}) begin
         nMiss++;
         $display("FAIL spurious_rvalid: V=%b I=%h req=%b addr=%h required 0 %h 1 00000400",
                  ValidF, InstF, bus.imem_req, bus.imem_addr, NOP);
      end
   endtask

   task automatic test_redirect_hold_stall();
      bus.imem_gnt = 1'b1;
      cyc();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h1234_5678;
      cyc();
      bus.imem_rvalid = 1'b0;
      nVec++;
      if ({ValidF, InstF, PCF} !== {1'b1, 32'h1234_5678, 32'h400}) begin
         nMiss++;
         $display("FAIL hold_capture: V=%b I=%h PC=%h required 1 12345678 00000400", ValidF, InstF, PCF);
      end
      StallF    = 1'b1;
      PCSrcE    = 1'b1;
      PCTargetE = 32'h500;
      cyc();
      PCSrcE = 1'b0;
      StallF = 1'b0;
      nVec++;
      if ({ValidF, InstF, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, 1'b1, 32'h500}) begin
         nMiss++;
         $display("FAIL redir_hold_stall: V=%b I=%h req=%b addr=%h required 0 %h 1 00000500",
                  ValidF, InstF, bus.imem_req, bus.imem_addr, NOP);
      end
   endtask

   task automatic test_async_reset();
      bus.imem_gnt = 1'b1;
      cyc();
      bus.imem_gnt = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      nVec++;
      if ({ValidF, InstF, PCF, PC4F, bus.imem_req, bus.imem_addr} !==
          {1'b0, NOP, 32'h0, 32'h4, 1'b1, 32'h0}) begin
         nMiss++;
         $display("FAIL async_reset: V=%b I=%h PC=%h PC4=%h req=%b addr=%h required 0 %h 0 4 1 0",
                  ValidF, InstF, PCF, PC4F, bus.imem_req, bus.imem_addr, NOP);
      end
      cyc();
      rst = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0004;
      cyc();
      bus.imem_rvalid = 1'b0;
      nVec++;
      if ({ValidF, InstF, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, 1'b1, 32'h0}) begin
         nMiss++;
         $display("FAIL late_rvalid: V=%b I=%h req=%b addr=%h required 0 %h 1 0",
                  ValidF, InstF, bus.imem_req, bus.imem_addr, NOP);
      end
      doFetch(32'h0, 0, 0);
   endtask

   task automatic test_wrap();
      wbus.imem_gnt = 1'b1;
      cyc();
      wbus.imem_gnt    = 1'b0;
      wbus.imem_rvalid = 1'b1;
      wbus.imem_rdata  = 32'h0000_0033;
      cyc();
      wbus.imem_rvalid = 1'b0;
      nVec++;
      if ({wValidF, wInstF, wPCF, wPC4F} !== {1'b1, 32'h33, 32'hFFFF_FFFC, 32'h0}) begin
         nMiss++;
         $display("FAIL wrap_first: V=%b I=%h PC=%h PC4=%h required 1 00000033 fffffffc 0",
                  wValidF, wInstF, wPCF, wPC4F);
      end
      cyc();
      nVec++;
      if ({wbus.imem_req, wbus.imem_addr} !== {1'b1, 32'h0}) begin
         nMiss++;
         $display("FAIL wrap_second_addr: req/addr=%b/%h required 1/00000000", wbus.imem_req, wbus.imem_addr);
      end
      wbus.imem_gnt = 1'b1;
      cyc();
      wbus.imem_gnt    = 1'b0;
      wbus.imem_rvalid = 1'b1;
      wbus.imem_rdata  = 32'h0000_0073;
      cyc();
      wbus.imem_rvalid = 1'b0;
      nVec++;
      if ({wValidF, wInstF, wPCF, wPC4F} !== {1'b1, 32'h73, 32'h0, 32'h4}) begin
         nMiss++;
         $display("FAIL wrap_second: V=%b I=%h PC=%h PC4=%h required 1 00000073 0 4",
                  wValidF, wInstF, wPCF, wPC4F);
      end
   endtask

   initial begin
      StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
      wStallF = 1'b0; wPCSrcE = 1'b0; wPCTargetE = 32'h0;
      wbus.imem_gnt = 1'b0; wbus.imem_rvalid = 1'b0; wbus.imem_rdata = 32'h0;
      rst = 1'b1;
      #1;
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_wait();
      test_redirect_coincident();
      test_redirect_req();
      test_redirect_hold_stall();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
